// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA/LCD raster timing generator:
//   - timing_t plus preset timings for common panel/monitor modes
//   - the eight colour-bar colours at full-scale RGB565, and a lookup function
package vga_timing_pkg;

   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
      bit hs_pol;
      bit vs_pol;
   } timing_t;

   localparam timing_t TIMING_480X272   = '{480,  2,   41,  2,   272,  2, 10, 2,  1'b0, 1'b0};
   localparam timing_t TIMING_640X480   = '{640,  16,  96,  48,  480,  10, 2, 33, 1'b0, 1'b0};
   localparam timing_t TIMING_800X600   = '{800,  40,  128, 88,  600,  1,  4, 23, 1'b1, 1'b1};
   localparam timing_t TIMING_1024X768  = '{1024, 24,  136, 160, 768,  3,  6, 29, 1'b0, 1'b0};
   localparam timing_t TIMING_1280X720  = '{1280, 110, 40,  220, 720,  5,  5, 20, 1'b1, 1'b1};
   localparam timing_t TIMING_1920X1080 = '{1920, 88,  44,  148, 1080, 4,  5, 36, 1'b1, 1'b1};

   localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB565_RED     = 16'hF800;
   localparam logic [15:0] RGB565_BLUE    = 16'h001F;
   localparam logic [15:0] RGB565_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_colour(input logic [2:0] k);
      case (k)
         3'd0:    bar_colour = RGB565_WHITE;
         3'd1:    bar_colour = RGB565_YELLOW;
         3'd2:    bar_colour = RGB565_CYAN;
         3'd3:    bar_colour = RGB565_GREEN;
         3'd4:    bar_colour = RGB565_MAGENTA;
         3'd5:    bar_colour = RGB565_RED;
         3'd6:    bar_colour = RGB565_BLUE;
         default: bar_colour = RGB565_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vga_pattern.sv
// vga_pattern
//   Test-pattern source that replaces upstream pixel data.
//   Ports:
//     i_x, i_y        pixel coordinate (already delayed to the output stage)
//     i_sel           0 = pass-through, 1 = 8 vertical bars, 2 = 16 px grid, 3 = white
//     i_red/grn/blu   upstream colour (IN_W each)
//     o_red/grn/blu   selected colour (IN_W each, full scale for pattern modes)
module vga_pattern
   import vga_timing_pkg::*;
#(
   parameter int CW       = 12,
   parameter int IN_W     = 10,
   parameter int H_ACTIVE = 640
) (
   input  logic [CW-1:0]   i_x,
   input  logic [CW-1:0]   i_y,
   input  logic [1:0]      i_sel,
   input  logic [IN_W-1:0] i_red,
   input  logic [IN_W-1:0] i_grn,
   input  logic [IN_W-1:0] i_blu,
   output logic [IN_W-1:0] o_red,
   output logic [IN_W-1:0] o_grn,
   output logic [IN_W-1:0] o_blu
);

   logic [2:0]  w_bar;
   logic [15:0] w_bar_rgb;
   logic        w_grid;
   logic        w_unused_y;

   // Bar index by threshold compare so no divider is needed; thresholds use
   // the same floor(k*H_ACTIVE/8) boundaries as the bar definition.
   always_comb begin
      w_bar = '0;
      for (int j = 1; j < 8; j++) begin
         if (i_x >= CW'(j * H_ACTIVE / 8)) w_bar = 3'(j);
      end
   end

   assign w_bar_rgb  = bar_colour(w_bar);
   assign w_grid     = (i_x[3:0] == 4'd0) || (i_y[3:0] == 4'd0);
   assign w_unused_y = ^i_y[CW-1:4];

   always_comb begin
      o_red = i_red;
      o_grn = i_grn;
      o_blu = i_blu;
      case (i_sel)
         2'd1: begin
            o_red = {IN_W{|w_bar_rgb[15:11]}};
            o_grn = {IN_W{|w_bar_rgb[10:5]}};
            o_blu = {IN_W{|w_bar_rgb[4:0]}};
         end
         2'd2: begin
            o_red = {IN_W{w_grid}};
            o_grn = {IN_W{w_grid}};
            o_blu = {IN_W{w_grid}};
         end
         2'd3: begin
            o_red = '1;
            o_grn = '1;
            o_blu = '1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA/LCD raster timing generator with a fetch-ahead pixel
//   request. Coordinates are requested RD_LAT cycles before the upstream
//   data is needed; syncs, DE and strobes are delayed RD_LAT+1 cycles so all
//   outputs leave the block mutually aligned.
//   Ports:
//     iCLK, rst                   pixel clock, synchronous active-high reset
//     iPattern_sel                pattern select (only with VGA_PATTERN_EN)
//     oReq, oCoord_X, oCoord_Y    pixel request and its coordinate
//     iRed, iGreen, iBlue         upstream pixel data, RD_LAT cycles after oReq
//     oVGA_R/G/B                  MSB-truncated output colour, 0 outside DE
//     oVGA_H_SYNC, oVGA_V_SYNC    syncs with HS_POL/VS_POL active level
//     oVGA_DE                     data enable
//     oFrame_start, oLine_start   first-pixel strobes aligned with DE
//   Build option: define VGA_PATTERN_EN to add the built-in test patterns.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 12,
   parameter int IN_W     = 10,
   parameter int R_W      = 5,
   parameter int G_W      = 6,
   parameter int B_W      = 5,
   parameter int RD_LAT   = 1
) (
   input  logic            iCLK,
   input  logic            rst,
`ifdef VGA_PATTERN_EN
   input  logic [1:0]      iPattern_sel,
`endif
   output logic            oReq,
   output logic [CW-1:0]   oCoord_X,
   output logic [CW-1:0]   oCoord_Y,
   input  logic [IN_W-1:0] iRed,
   input  logic [IN_W-1:0] iGreen,
   input  logic [IN_W-1:0] iBlue,
   output logic [R_W-1:0]  oVGA_R,
   output logic [G_W-1:0]  oVGA_G,
   output logic [B_W-1:0]  oVGA_B,
   output logic            oVGA_H_SYNC,
   output logic            oVGA_V_SYNC,
   output logic            oVGA_DE,
   output logic            oFrame_start,
   output logic            oLine_start
);

   localparam int H_BLANK = H_FP + H_SYNC + H_BP;
   localparam int H_TOTAL = H_BLANK + H_ACTIVE;
   localparam int V_BLANK = V_FP + V_SYNC + V_BP;
   localparam int V_TOTAL = V_BLANK + V_ACTIVE;

   localparam logic [CW-1:0] C_H_LAST     = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] C_V_LAST     = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] C_H_BLANK    = CW'(H_BLANK);
   localparam logic [CW-1:0] C_V_BLANK    = CW'(V_BLANK);
   localparam logic [CW-1:0] C_H_SYNC_BEG = CW'(H_FP);
   localparam logic [CW-1:0] C_H_SYNC_END = CW'(H_FP + H_SYNC);
   localparam logic [CW-1:0] C_V_SYNC_BEG = CW'(V_FP);
   localparam logic [CW-1:0] C_V_SYNC_END = CW'(V_FP + V_SYNC);

   generate
      if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_err_cw
         $error("vga_timing_gen: CW cannot hold H_TOTAL-1 or V_TOTAL-1");
      end
      if (RD_LAT < 0 || RD_LAT > 4) begin : g_err_lat
         $error("vga_timing_gen: RD_LAT must be 0..4");
      end
      if (R_W > IN_W || G_W > IN_W || B_W > IN_W) begin : g_err_w
         $error("vga_timing_gen: output channel wider than IN_W");
      end
   endgenerate

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
      logic fs;
      logic ls;
`ifdef VGA_PATTERN_EN
      logic [CW-1:0] x;
      logic [CW-1:0] y;
`endif
   } pipe_t;

   logic [CW-1:0]   r_h_cnt;
   logic [CW-1:0]   r_v_cnt;
   logic            w_act;
   logic [CW-1:0]   w_x;
   logic [CW-1:0]   w_y;
   pipe_t           w_s0;
   pipe_t           w_del;
   logic [IN_W-1:0] w_red;
   logic [IN_W-1:0] w_grn;
   logic [IN_W-1:0] w_blu;
   logic            w_unused_colour;

   always_ff @(posedge iCLK) begin
      if (rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == C_H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + CW'(1);
      end else begin
         r_h_cnt <= r_h_cnt + CW'(1);
      end
   end

   assign w_act    = (r_h_cnt >= C_H_BLANK) && (r_v_cnt >= C_V_BLANK);
   assign w_x      = w_act ? r_h_cnt - C_H_BLANK : '0;
   assign w_y      = w_act ? r_v_cnt - C_V_BLANK : '0;
   assign oReq     = w_act;
   assign oCoord_X = w_x;
   assign oCoord_Y = w_y;

   always_comb begin
      w_s0     = '0;
      w_s0.hs  = (r_h_cnt >= C_H_SYNC_BEG) && (r_h_cnt < C_H_SYNC_END);
      w_s0.vs  = (r_v_cnt >= C_V_SYNC_BEG) && (r_v_cnt < C_V_SYNC_END);
      w_s0.act = w_act;
      w_s0.fs  = w_act && (w_x == '0) && (w_y == '0);
      w_s0.ls  = w_act && (w_x == '0);
`ifdef VGA_PATTERN_EN
      w_s0.x   = w_x;
      w_s0.y   = w_y;
`endif
   end

   // RD_LAT stages here; the output register below is the final stage, so
   // control reaches the pins RD_LAT+1 cycles after the request.
   generate
      if (RD_LAT == 0) begin : g_nodly
         assign w_del = w_s0;
      end else begin : g_dly
         pipe_t r_dly [RD_LAT];
         always_ff @(posedge iCLK) begin
            if (rst) begin
               for (int k = 0; k < RD_LAT; k++) r_dly[k] <= '0;
            end else begin
               r_dly[0] <= w_s0;
               for (int k = 1; k < RD_LAT; k++) r_dly[k] <= r_dly[k-1];
            end
         end
         assign w_del = r_dly[RD_LAT-1];
      end
   endgenerate

`ifdef VGA_PATTERN_EN
   logic [1:0] r_pat_sel;
   logic [1:0] w_sel;

   // The new selection already applies to the frame's first pixel.
   assign w_sel = w_del.fs ? iPattern_sel : r_pat_sel;

   always_ff @(posedge iCLK) begin
      if (rst)           r_pat_sel <= '0;
      else if (w_del.fs) r_pat_sel <= iPattern_sel;
   end

   vga_pattern #(
      .CW       (CW),
      .IN_W     (IN_W),
      .H_ACTIVE (H_ACTIVE)
   ) u_pattern (
      .i_x   (w_del.x),
      .i_y   (w_del.y),
      .i_sel (w_sel),
      .i_red (iRed),
      .i_grn (iGreen),
      .i_blu (iBlue),
      .o_red (w_red),
      .o_grn (w_grn),
      .o_blu (w_blu)
   );
`else
   assign w_red = iRed;
   assign w_grn = iGreen;
   assign w_blu = iBlue;
`endif

   // Truncation drops LSBs on purpose.
   assign w_unused_colour = ^{w_red, w_grn, w_blu};

   always_ff @(posedge iCLK) begin
      if (rst) begin
         oVGA_R       <= '0;
         oVGA_G       <= '0;
         oVGA_B       <= '0;
         oVGA_DE      <= 1'b0;
         oFrame_start <= 1'b0;
         oLine_start  <= 1'b0;
         oVGA_H_SYNC  <= ~HS_POL;
         oVGA_V_SYNC  <= ~VS_POL;
      end else begin
         oVGA_DE      <= w_del.act;
         oFrame_start <= w_del.fs;
         oLine_start  <= w_del.ls;
         oVGA_H_SYNC  <= w_del.hs ? HS_POL : ~HS_POL;
         oVGA_V_SYNC  <= w_del.vs ? VS_POL : ~VS_POL;
         if (w_del.act) begin
            oVGA_R <= w_red[IN_W-1 -: R_W];
            oVGA_G <= w_grn[IN_W-1 -: G_W];
            oVGA_B <= w_blu[IN_W-1 -: B_W];
         end else begin
            oVGA_R <= '0;
            oVGA_G <= '0;
            oVGA_B <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen with a tiny raster (H 8/2/3/1, V 4/1/2/1,
// RD_LAT=1, HS_POL=1, VS_POL=0). Pattern checks are added when the bundle
// is built with VGA_PATTERN_EN.
module tb_vga_timing_gen;

   localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 1;
   localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int H_BLANK = H_FP + H_SYNC + H_BP;
   localparam int H_TOTAL = H_BLANK + H_ACTIVE;
   localparam int V_BLANK = V_FP + V_SYNC + V_BP;
   localparam int V_TOTAL = V_BLANK + V_ACTIVE;
   localparam int RD_LAT = 1, CW = 12, IN_W = 10;
   localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
   localparam int NV = 5;

   logic            iCLK;
   logic            rst;
   logic            oReq;
   logic [CW-1:0]   oCoord_X, oCoord_Y;
   logic [IN_W-1:0] iRed, iGreen, iBlue;
   logic [4:0]      oVGA_R;
   logic [5:0]      oVGA_G;
   logic [4:0]      oVGA_B;
   logic            oVGA_H_SYNC, oVGA_V_SYNC, oVGA_DE, oFrame_start, oLine_start;
`ifdef VGA_PATTERN_EN
   logic [1:0]      iPattern_sel;
`endif

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .IN_W(IN_W),
      .R_W(5), .G_W(6), .B_W(5), .RD_LAT(RD_LAT)
   ) dut (
      .iCLK(iCLK), .rst(rst),
`ifdef VGA_PATTERN_EN
      .iPattern_sel(iPattern_sel),
`endif
      .oReq(oReq), .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y),
      .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
      .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
      .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC), .oVGA_DE(oVGA_DE),
      .oFrame_start(oFrame_start), .oLine_start(oLine_start)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [9:0] r, g, b;
      logic [4:0] er;
      logic [5:0] eg;
      logic [4:0] eb;
   } vec_t;

   typedef struct {
      int         cyc;
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      logic       fs, ls;
   } sb_t;

   typedef struct {
      int due;
      int idx;
   } up_t;

   vec_t vt [NV];
   sb_t  sb_q [$];
   up_t  up_q [$];

   int n_chk = 0, n_pass = 0;
   int cyc = 0, pix_n = 0;
   bit colour_chk = 1'b1;
   int hs_hi, vs_lo, fs_n, ls_n, last_fs, first_de, first_req;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s: got no match expected scoreboard entry at cycle %0d", name, cyc);
   endtask

   task automatic stats_clear();
      hs_hi = 0; vs_lo = 0; fs_n = 0; ls_n = 0; last_fs = 0; first_de = -1; first_req = -1;
   endtask

   task automatic step_checks();
      int h, v, d, hd, vd;
      bit act, exp_hs, exp_vs, exp_de;
      sb_t e;
      up_t u;
      h   = cyc % H_TOTAL;
      v   = (cyc / H_TOTAL) % V_TOTAL;
      act = (h >= H_BLANK) && (v >= V_BLANK);
      chk("oReq", oReq, act);
      chk("coord_x", oCoord_X, act ? h - H_BLANK : 0);
      chk("coord_y", oCoord_Y, act ? v - V_BLANK : 0);
      if (act) begin
         u.due = cyc + RD_LAT;
         u.idx = pix_n % NV;
         up_q.push_back(u);
         e.cyc = cyc + RD_LAT + 1;
         e.r = vt[u.idx].er; e.g = vt[u.idx].eg; e.b = vt[u.idx].eb;
         e.fs = (h == H_BLANK) && (v == V_BLANK);
         e.ls = (h == H_BLANK);
         sb_q.push_back(e);
         pix_n++;
         if (first_req < 0) first_req = cyc;
      end
      if (up_q.size() > 0 && up_q[0].due == cyc) begin
         u = up_q.pop_front();
         iRed = vt[u.idx].r; iGreen = vt[u.idx].g; iBlue = vt[u.idx].b;
      end else begin
         iRed = 10'($urandom); iGreen = 10'($urandom); iBlue = 10'($urandom);
      end

      d = cyc - (RD_LAT + 1);
      exp_hs = ~HS_POL; exp_vs = ~VS_POL; exp_de = 1'b0;
      if (d >= 0) begin
         hd = d % H_TOTAL;
         vd = (d / H_TOTAL) % V_TOTAL;
         if (hd >= H_FP && hd < H_FP + H_SYNC) exp_hs = HS_POL;
         if (vd >= V_FP && vd < V_FP + V_SYNC) exp_vs = VS_POL;
         exp_de = (hd >= H_BLANK) && (vd >= V_BLANK);
      end
      chk("h_sync", oVGA_H_SYNC, exp_hs);
      chk("v_sync", oVGA_V_SYNC, exp_vs);
      chk("de", oVGA_DE, exp_de);

      if (oVGA_DE === 1'b1) begin
         if (sb_q.size() == 0) fail_now("sb_empty");
         else begin
            e = sb_q.pop_front();
            chk("de_latency", cyc, e.cyc);
            if (colour_chk) begin
               chk("red", oVGA_R, e.r);
               chk("green", oVGA_G, e.g);
               chk("blue", oVGA_B, e.b);
            end
            chk("frame_start", oFrame_start, e.fs);
            chk("line_start", oLine_start, e.ls);
         end
         if (first_de < 0) first_de = cyc;
      end else begin
         chk("blank_rgb", {oVGA_R, oVGA_G, oVGA_B}, 0);
         chk("blank_strobes", {oFrame_start, oLine_start}, 0);
         if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            fail_now("de_missing");
            void'(sb_q.pop_front());
         end
      end

      if (d >= 0 && d < 3 * H_TOTAL * V_TOTAL) begin
         if (oVGA_H_SYNC === 1'b1) hs_hi++;
         if (oVGA_V_SYNC === 1'b0) vs_lo++;
      end
      if (oFrame_start === 1'b1) begin
         fs_n++;
         if (fs_n == 1) chk("first_frame_start", cyc, 64);
         else chk("frame_period", cyc - last_fs, 112);
         last_fs = cyc;
      end
      if (oLine_start === 1'b1) ls_n++;
   endtask

   task automatic reset_hold(input int n);
      rst = 1'b1;
      repeat (n) begin
         @(negedge iCLK);
         chk("rst_req", oReq, 0);
         chk("rst_coords", {oCoord_X, oCoord_Y}, 0);
         chk("rst_rgb", {oVGA_R, oVGA_G, oVGA_B}, 0);
         chk("rst_de_strobes", {oVGA_DE, oFrame_start, oLine_start}, 0);
         chk("rst_h_sync", oVGA_H_SYNC, 1'b0);
         chk("rst_v_sync", oVGA_V_SYNC, 1'b1);
      end
      rst = 1'b0;
      sb_q.delete();
      up_q.delete();
      cyc = 0;
      pix_n = 0;
      stats_clear();
      step_checks();
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge iCLK);
         cyc++;
         step_checks();
      end
   endtask

   initial begin
      vt[0] = '{r:10'h3FF, g:10'h155, b:10'h21F, er:5'h1F, eg:6'h15, eb:5'h10};
      vt[1] = '{r:10'h000, g:10'h3FF, b:10'h000, er:5'h00, eg:6'h3F, eb:5'h00};
      vt[2] = '{r:10'h2A5, g:10'h0F0, b:10'h3E0, er:5'h15, eg:6'h0F, eb:5'h1F};
      vt[3] = '{r:10'h07F, g:10'h200, b:10'h01F, er:5'h03, eg:6'h20, eb:5'h00};
      vt[4] = '{r:10'h001, g:10'h3FE, b:10'h3E1, er:5'h00, eg:6'h3F, eb:5'h1F};
      rst = 1'b1;
      iRed = '0; iGreen = '0; iBlue = '0;
`ifdef VGA_PATTERN_EN
      iPattern_sel = 2'd0;
`endif

      // Power-on reset, then three full frames plus the first DE offset.
      reset_hold(3);
      run(399);
      chk("first_req_cycle", first_req, 62);
      chk("first_de_cycle", first_de, 64);
      chk("h_sync_high_3frames", hs_hi, 72);
      chk("v_sync_low_3frames", vs_lo, 84);
      chk("frame_start_count", fs_n, 3);
      chk("line_start_count", ls_n, 12);

      // One-cycle reset at h_cnt=9, v_cnt=5 with pixels in flight.
      run(16);
      chk("pre_reset_position", cyc % H_TOTAL + 100 * ((cyc / H_TOTAL) % V_TOTAL), 509);
      reset_hold(1);
      run(70);
      chk("post_reset_first_req", first_req, 62);
      chk("post_reset_first_de", first_de, 64);
      chk("post_reset_frame_start", fs_n, 1);

`ifdef VGA_PATTERN_EN
      iPattern_sel = 2'd1;
      colour_chk = 1'b0;
      reset_hold(2);
      for (int i = 0; i < 180; i++) begin
         @(negedge iCLK);
         cyc++;
         step_checks();
         if (cyc == 64)  chk("bars_x0_white", {oVGA_R, oVGA_G, oVGA_B}, {5'h1F, 6'h3F, 5'h1F});
         if (cyc == 65)  chk("bars_x1_yellow", {oVGA_R, oVGA_G, oVGA_B}, {5'h1F, 6'h3F, 5'h00});
         if (cyc == 90)  iPattern_sel = 2'd3;
         if (cyc == 107) chk("sel_change_held", {oVGA_R, oVGA_G, oVGA_B}, {5'h1F, 6'h3F, 5'h00});
         if (cyc == 176) chk("next_frame_x0_white", {oVGA_R, oVGA_G, oVGA_B}, {5'h1F, 6'h3F, 5'h1F});
         if (cyc == 177) chk("next_frame_x1_white", {oVGA_R, oVGA_G, oVGA_B}, {5'h1F, 6'h3F, 5'h1F});
      end
      colour_chk = 1'b1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
